// File: rtl/e_mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : e_mdu_pkg
//  Purpose  : Shared MDU opcode encodings and default latencies for the
//             decoder, hazard unit and E-stage multiply/divide unit.
//  Revision : 1.0  initial release
// ============================================================================
package e_mdu_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

    function automatic logic md_is_muldiv(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/e_mdu.sv
`default_nettype none
// ============================================================================
//  Module   : e_mdu
//  Purpose  : E-stage multiply/divide unit with architectural HI/LO and a
//             fixed-latency busy window before results are committed.
//  Revision : 1.0  initial release
// ============================================================================
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MD_op,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    output logic        E_MD_start,
    output logic        E_MD_busy,
    output logic [31:0] E_MD_out,
    output logic [31:0] E_HI,
    output logic [31:0] E_LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [63:0]      temp_q, temp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             wr_q, wr_d;

    logic [63:0] w_sprod;
    logic [63:0] w_uprod;
    logic [31:0] w_squot, w_srem;
    logic [31:0] w_uquot, w_urem;
    logic        w_b_zero;
    logic        w_ovf;

    // Results are formed at start and held in temp until the commit edge.
    always_comb begin
        w_sprod  = $signed({{32{E_A[31]}}, E_A}) * $signed({{32{E_B[31]}}, E_B});
        w_uprod  = {32'd0, E_A} * {32'd0, E_B};
        w_b_zero = (E_B == 32'd0);
        w_ovf    = (E_A == 32'h8000_0000) && (E_B == 32'hFFFF_FFFF);
        w_squot  = 32'd0;
        w_srem   = 32'd0;
        w_uquot  = 32'd0;
        w_urem   = 32'd0;
        // The most-negative / -1 case is pinned explicitly rather than relying
        // on the host arithmetic for an overflowing signed divide.
        if (w_ovf) begin
            w_squot = 32'h8000_0000;
        end else if (!w_b_zero) begin
            w_squot = $signed(E_A) / $signed(E_B);
            w_srem  = $signed(E_A) % $signed(E_B);
        end
        if (!w_b_zero) begin
            w_uquot = E_A / E_B;
            w_urem  = E_A % E_B;
        end
    end

    always_comb begin
        hi_d       = hi_q;
        lo_d       = lo_q;
        temp_d     = temp_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        wr_d       = wr_q;
        E_MD_start = md_is_muldiv(E_MD_op) && !busy_q;

        if (busy_q) begin
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
                cnt_d  = '0;
                if (wr_q) begin
                    hi_d = temp_q[63:32];
                    lo_d = temp_q[31:0];
                end
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else begin
            case (E_MD_op)
                MD_MULT:  temp_d = w_sprod;
                MD_MULTU: temp_d = w_uprod;
                MD_DIV:   temp_d = {w_srem, w_squot};
                MD_DIVU:  temp_d = {w_urem, w_uquot};
                MD_MTHI:  hi_d   = E_A;
                MD_MTLO:  lo_d   = E_A;
                default:  ;
            endcase
            if (E_MD_start) begin
                busy_d = 1'b1;
                cnt_d  = ((E_MD_op == MD_MULT) || (E_MD_op == MD_MULTU)) ?
                         CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                // A divide by zero still occupies the unit but never commits.
                wr_d   = !(((E_MD_op == MD_DIV) || (E_MD_op == MD_DIVU)) && w_b_zero);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            temp_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            wr_q   <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            temp_q <= temp_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            wr_q   <= wr_d;
        end
    end

    always_comb begin
        case (E_MD_op)
            MD_MFHI: E_MD_out = hi_q;
            MD_MFLO: E_MD_out = lo_q;
            default: E_MD_out = 32'd0;
        endcase
    end

    assign E_MD_busy = busy_q;
    assign E_HI      = hi_q;
    assign E_LO      = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_e_mdu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_e_mdu
//  Purpose  : Scoreboard bench for e_mdu: HI/LO results, busy window, MF/MT
//             ops, divide-by-zero, busy-time op rejection and reset abort.
//  Revision : 1.0  initial release
// ============================================================================
module tb_e_mdu;
    import e_mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic [3:0]  E_MD_op;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        E_MD_start;
    logic        E_MD_busy;
    logic [31:0] E_MD_out;
    logic [31:0] E_HI;
    logic [31:0] E_LO;

    int          n_checks;
    int          n_pass;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [63:0] sb_q[$];

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .E_MD_op    (E_MD_op),
        .E_A        (E_A),
        .E_B        (E_B),
        .E_MD_start (E_MD_start),
        .E_MD_busy  (E_MD_busy),
        .E_MD_out   (E_MD_out),
        .E_HI       (E_HI),
        .E_LO       (E_LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] hi,
                                          input logic [31:0] lo);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            MD_MULT:  begin q = sa * sb; p = q; return p; end
            MD_MULTU: return {32'd0, a} * {32'd0, b};
            MD_DIV: begin
                if (b == 32'd0) return {hi, lo};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            MD_DIVU: begin
                if (b == 32'd0) return {hi, lo};
                return {a % b, a / b};
            end
            default: return {hi, lo};
        endcase
    endfunction

    // Issue one MULT/DIV op, hold busy_op on the bus for the whole busy window
    // (it must be ignored), then compare the committed HI/LO from the scoreboard.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int exp_cycles, input logic [3:0] busy_op);
        logic [63:0] exp;
        logic [31:0] old_hi;
        int n;
        old_hi = m_hi;
        exp = model(op, a, b, m_hi, m_lo);
        sb_q.push_back(exp);
        m_hi = exp[63:32];
        m_lo = exp[31:0];
        E_MD_op = op;
        E_A = a;
        E_B = b;
        @(negedge clk);
        check("start", {63'd0, E_MD_start}, 64'd1);
        step();
        E_MD_op = busy_op;
        E_A = 32'hDEAD_0000;
        E_B = 32'd3;
        n = 0;
        while (E_MD_busy && n < 200) begin
            @(negedge clk);
            if (n == 0) check("start_while_busy", {63'd0, E_MD_start}, 64'd0);
            if (busy_op == MD_MFHI && n == 2) check("mfhi_while_busy", {32'd0, E_MD_out}, {32'd0, old_hi});
            n++;
            step();
        end
        E_MD_op = MD_NONE;
        check("busy_cycles", 64'(n), 64'(exp_cycles));
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            exp = sb_q.pop_front();
            check("hi", {32'd0, E_HI}, {32'd0, exp[63:32]});
            check("lo", {32'd0, E_LO}, {32'd0, exp[31:0]});
        end
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] v);
        E_MD_op = op;
        E_A = v;
        step();
        E_MD_op = MD_NONE;
        if (op == MD_MTHI) m_hi = v;
        else m_lo = v;
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        reset = 1'b1;
        E_MD_op = MD_NONE;
        E_A = 32'd0;
        E_B = 32'd0;
        repeat (2) step();
        reset = 1'b0;
        E_MD_op = MD_MFHI;
        @(negedge clk);
        check("rst_busy", {63'd0, E_MD_busy}, 64'd0);
        check("rst_hi", {32'd0, E_HI}, 64'd0);
        check("rst_lo", {32'd0, E_LO}, 64'd0);
        check("rst_out", {32'd0, E_MD_out}, 64'd0);
        check("rst_start", {63'd0, E_MD_start}, 64'd0);
        step();
        E_MD_op = MD_NONE;

        run_op(MD_MULT,  32'hFFFF_FFFE, 32'd3, 5, MD_NONE);
        run_op(MD_MULTU, 32'hFFFF_FFFE, 32'd3, 5, MD_MULT);
        run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2, 10, MD_MFHI);
        E_MD_op = MD_MFLO;
        @(negedge clk);
        check("mflo_after_div", {32'd0, E_MD_out}, 64'h0000_0000_FFFF_FFFD);
        step();
        E_MD_op = MD_NONE;

        // Back-to-back start directly on the cycle after a divide completes.
        run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, MD_MTHI);
        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, MD_MTLO);

        mt(MD_MTHI, 32'h1234);
        mt(MD_MTLO, 32'h5678);
        E_MD_op = MD_MFHI;
        @(negedge clk);
        check("mthi", {32'd0, E_MD_out}, {32'd0, m_hi});
        step();
        E_MD_op = MD_NONE;
        run_op(MD_DIVU, 32'd77, 32'd0, 10, MD_NONE);
        run_op(MD_DIVU, 32'd100, 32'd7, 10, MD_MFHI);
        run_op(MD_DIV,  32'd7, 32'hFFFF_FFFE, 10, MD_DIVU);

        // Reset mid-operation, with an MTHI presented in the reset cycle.
        E_MD_op = MD_MULT;
        E_A = 32'd3;
        E_B = 32'd4;
        @(negedge clk);
        check("abort_start", {63'd0, E_MD_start}, 64'd1);
        step();
        E_MD_op = MD_NONE;
        step();
        E_MD_op = MD_MULT;
        @(negedge clk);
        check("abort_restart_blocked", {63'd0, E_MD_start}, 64'd0);
        step();
        E_MD_op = MD_MTHI;
        E_A = 32'h55;
        reset = 1'b1;
        step();
        reset = 1'b0;
        E_MD_op = MD_NONE;
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        check("abort_busy", {63'd0, E_MD_busy}, 64'd0);
        check("abort_hi", {32'd0, E_HI}, 64'd0);
        check("abort_lo", {32'd0, E_LO}, 64'd0);
        repeat (8) step();
        @(negedge clk);
        check("abort_late_busy", {63'd0, E_MD_busy}, 64'd0);
        check("abort_late_hi", {32'd0, E_HI}, 64'd0);
        check("abort_late_lo", {32'd0, E_LO}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/e_mdu.md
E_MDU -- requirements
Module: e_mdu

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, the busy duration in cycles for MULT/MULTU.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, the busy duration in cycles for DIV/DIVU.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high.
REQ-005 SHALL have port E_MD_op, input, 4, E-stage MDU opcode: NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
REQ-006 SHALL have port E_A, input, 32, forwarded rs operand.
REQ-007 SHALL have port E_B, input, 32, forwarded rt operand.
REQ-008 SHALL have port E_MD_start, output, 1, combinational; high when E_MD_op is MULT/MULTU/DIV/DIVU and busy=0.
REQ-009 SHALL have port E_MD_busy, output, 1, registered; high while an operation is in flight.
REQ-010 SHALL have port E_MD_out, output, 32, combinational; HI for MFHI, LO for MFLO, else 0; this value is muxed into E_C for M_reg.
REQ-011 SHALL have port E_HI, output, 32, architectural HI, debug only.
REQ-012 SHALL have port E_LO, output, 32, architectural LO, debug only.

Function
REQ-013 On a start cycle T: SHALL latch the operands and opcode, set busy<=1 and set cnt<=MULT_CYCLES or DIV_CYCLES.
REQ-014 busy SHALL be high for exactly N cycles, T+1..T+N; at the edge ending T+N (cnt==1), HI/LO SHALL be updated and busy<=0; new HI/LO are visible from T+N+1.
REQ-015 cnt SHALL decrement by 1 per cycle while busy; no wrap; cnt==0 when idle.
REQ-016 MULT SHALL compute the signed 64-bit product of E_A and E_B; MULTU the unsigned product; {HI,LO} = product.
REQ-017 DIV SHALL produce a signed quotient truncated toward zero in LO and a remainder carrying the dividend's sign in HI.
REQ-018 DIV with 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-019 DIVU SHALL produce an unsigned quotient in LO and unsigned remainder in HI.
REQ-020 Divide by zero (B==0, DIV or DIVU) SHALL still hold busy for DIV_CYCLES and leave HI/LO unchanged.
REQ-021 MTHI SHALL set HI<=E_A and MTLO SHALL set LO<=E_A at the edge ending the cycle presented, only when busy=0.
REQ-022 Any MULT/DIV/MTHI/MTLO op presented while busy=1 SHALL be ignored: no restart, no HI/LO write. (The hazard unit prevents this; behaviour is defined regardless.)
REQ-023 MFHI/MFLO while busy SHALL return the pre-operation HI/LO; stalling is the hazard unit's job.
REQ-024 On the final busy cycle (cnt==1), a new op SHALL be ignored because busy=1; back-to-back start SHALL be possible from T+N+1.
REQ-025 Result computation MAY be done at start and held in an internal 64-bit temp; only the commit time is architectural.

Reset
REQ-026 On reset, at the next edge: HI=0, LO=0, busy=0, cnt=0, temp=0.
REQ-027 Reset SHALL take priority over a start or MT* op in the same cycle.
REQ-028 Reset mid-operation SHALL discard the pending result; HI/LO SHALL stay 0.

Structure
REQ-029 The MD_* opcode encodings SHALL live in the shared def.v include, used by the decoder and hazard unit.
REQ-030 MULT_CYCLES and DIV_CYCLES defaults SHALL live in the shared def.v include.
REQ-031 SHALL be a single module; no sub-module; signed/unsigned handled by $signed casts, not a separate divider.

Verification
REQ-032 MULT, A=0xFFFFFFFE, B=3 -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-033 MULTU, same operands -> HI=0x00000002, LO=0xFFFFFFFA after 5 cycles.
REQ-034 DIV, A=0xFFFFFFF9, B=2 -> busy 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF; MFLO then gives E_MD_out=0xFFFFFFFD.
REQ-035 MTHI A=0x1234, MTLO A=0x5678, then DIVU B=0 -> busy 10 cycles; HI=0x1234, LO=0x5678 unchanged.
REQ-036 MULT start, MULT presented again at T+2, then reset asserted at T+3 -> second op ignored (cnt unaffected); busy=0 and HI=LO=0 from T+4, no later commit.
REQ-037 MULTU A=B=0xFFFFFFFF immediately following a completed DIV (start at T+N+1) -> accepted; HI=0xFFFFFFFE, LO=0x00000001.
